// File: rtl/panel_pkg.sv
// Shared types and default configuration for the front-panel input conditioner.
package panel_pkg;

   localparam int unsigned DefDebounceCycles = 4;
   localparam int unsigned DefResetStretch   = 4;
   localparam int unsigned DefRepeatDelay    = 16;
   localparam int unsigned DefRepeatPeriod   = 8;

   typedef enum logic [1:0] {
      Idle    = 2'd0,
      Hold    = 2'd1,
      Release = 2'd2
   } rst_state_e;

   // Bits needed for a counter that must reach max_val.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : int'($clog2(max_val + 1));
   endfunction

endpackage

// File: rtl/panel_input_conditioner_if.sv
// Front-panel signal bundle: raw panel inputs and the conditioned CPU-side outputs.
interface panel_input_conditioner_if;

   logic       s_button;
   logic       w_button;
   logic [3:0] switch_in;
   logic       step_pulse;
   logic       cpu_reset;
   logic [3:0] switch_val;
   logic       switch_chg;

   modport master (
      output s_button, w_button, switch_in,
      input  step_pulse, cpu_reset, switch_val, switch_chg
   );

   modport slave (
      input  s_button, w_button, switch_in,
      output step_pulse, cpu_reset, switch_val, switch_chg
   );

endinterface

// File: rtl/debounce_cell.sv
// One-bit input conditioner: two-flop synchronizer followed by a hold-time debouncer.
module debounce_cell
   import panel_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw_i,
   output logic stable_o,
   output logic stable_next_o
);

   localparam int unsigned    CntW    = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

   logic            sync1_q, sync2_q;
   logic            stable_q, stable_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   // Counter only ever climbs to CntLast before the level is accepted and it clears.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
         if (cnt_q >= CntLast) begin
            stable_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= raw_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable_o      = stable_q;
   assign stable_next_o = stable_d;

endmodule

// File: rtl/panel_input_conditioner.sv
// Front-panel conditioner: debounced step/reset buttons and switches, stretched CPU reset.
// Optional auto-repeat of the step button is enabled by defining PANEL_AUTO_REPEAT_EN.
module panel_input_conditioner
   import panel_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
   parameter int unsigned RESET_STRETCH   = DefResetStretch,
   parameter int unsigned REPEAT_DELAY    = DefRepeatDelay,
   parameter int unsigned REPEAT_PERIOD   = DefRepeatPeriod
) (
   input logic                       clk,
   input logic                       reset_n,
   panel_input_conditioner_if.slave  pnl
);

   localparam int unsigned     StW    = cnt_width(RESET_STRETCH);
   localparam logic [StW-1:0]  StLast = StW'(RESET_STRETCH - 1);

   // Bit 0 = step, bit 1 = CPU reset, bits 5:2 = switches.
   logic [5:0] raw, stable, stable_next;

   assign raw = {pnl.switch_in, pnl.w_button, pnl.s_button};

   for (genvar i = 0; i < 6; i++) begin : g_cell
      debounce_cell #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_cell (
         .clk          (clk),
         .reset_n      (reset_n),
         .raw_i        (raw[i]),
         .stable_o     (stable[i]),
         .stable_next_o(stable_next[i])
      );
   end

   logic s_rise, s_held, w_next, w_fall;

   // Decisions use next-state levels so they take effect on the same edge as the level.
   assign s_rise = stable_next[0] & ~stable[0];
   assign s_held = stable_next[0] & stable[0];
   assign w_next = stable_next[1];
   assign w_fall = stable[1] & ~stable_next[1];

   rst_state_e     state_q, state_d;
   logic [StW-1:0] str_cnt_q, str_cnt_d;

   always_comb begin
      state_d   = state_q;
      str_cnt_d = str_cnt_q;
      unique case (state_q)
         Idle: begin
            if (w_next) begin
               state_d   = Hold;
               str_cnt_d = '0;
            end
         end
         Hold: begin
            if (w_fall) begin
               state_d   = Release;
               str_cnt_d = '0;
            end
         end
         Release: begin
            if (w_next) begin
               state_d   = Hold;
               str_cnt_d = '0;
            end else if (str_cnt_q >= StLast) begin
               state_d = Idle;
            end else begin
               str_cnt_d = str_cnt_q + StW'(1);
            end
         end
         default: begin
            state_d   = Release;
            str_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= Release;
         str_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         str_cnt_q <= str_cnt_d;
      end
   end

   logic step_first, step_fire;

   assign step_first = s_rise & (state_d == Idle);

`ifdef PANEL_AUTO_REPEAT_EN
   localparam int unsigned     RptMax         = (REPEAT_DELAY > REPEAT_PERIOD) ?
                                                REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned     RptW           = cnt_width(RptMax);
   localparam logic [RptW-1:0] RptDelayLast   = RptW'(REPEAT_DELAY - 1);
   localparam logic [RptW-1:0] RptPeriodLast  = RptW'(REPEAT_PERIOD - 1);

   logic            rpt_armed_q, rpt_armed_d;
   logic            rpt_first_q, rpt_first_d;
   logic [RptW-1:0] rpt_cnt_q, rpt_cnt_d;
   logic            rpt_fire;

   // Armed by the press pulse; any release or CPU reset disarms until the next press.
   always_comb begin
      rpt_armed_d = 1'b0;
      rpt_first_d = 1'b1;
      rpt_cnt_d   = '0;
      rpt_fire    = 1'b0;
      if (step_first) begin
         rpt_armed_d = 1'b1;
      end else if (rpt_armed_q && s_held && (state_d == Idle)) begin
         rpt_armed_d = 1'b1;
         rpt_first_d = rpt_first_q;
         if (rpt_cnt_q >= (rpt_first_q ? RptDelayLast : RptPeriodLast)) begin
            rpt_fire    = 1'b1;
            rpt_first_d = 1'b0;
         end else begin
            rpt_cnt_d = rpt_cnt_q + RptW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rpt_armed_q <= 1'b0;
         rpt_first_q <= 1'b1;
         rpt_cnt_q   <= '0;
      end else begin
         rpt_armed_q <= rpt_armed_d;
         rpt_first_q <= rpt_first_d;
         rpt_cnt_q   <= rpt_cnt_d;
      end
   end

   assign step_fire = step_first | rpt_fire;
`else
   assign step_fire = step_first;
`endif

   logic step_pulse_q, switch_chg_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         step_pulse_q <= 1'b0;
         switch_chg_q <= 1'b0;
      end else begin
         step_pulse_q <= step_fire;
         switch_chg_q <= |(stable_next[5:2] ^ stable[5:2]);
      end
   end

   assign pnl.step_pulse = step_pulse_q;
   assign pnl.cpu_reset  = (state_q != Idle);
   assign pnl.switch_val = stable[5:2];
   assign pnl.switch_chg = switch_chg_q;

endmodule

// File: tb/tb_panel_input_conditioner.sv
// Scoreboard bench for panel_input_conditioner: expected pulse cycles are queued at stimulus time.
module tb_panel_input_conditioner;

   logic clk = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   int         step_q[$];
   int         sw_cyc_q[$];
   logic [3:0] sw_val_q[$];

   panel_input_conditioner_if pif ();

   panel_input_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .RESET_STRETCH  (4),
      .REPEAT_DELAY   (16),
      .REPEAT_PERIOD  (8)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .pnl    (pif)
   );

   always #5 clk = ~clk;

   // Advance one cycle, then retire any output pulse against the scoreboard.
   task automatic tick();
      int         exp_c;
      logic [3:0] exp_v;
      @(posedge clk);
      cyc++;
      #1;
      if (pif.step_pulse === 1'b1) begin
         checks++;
         if (step_q.size() == 0) begin
            errors++;
            $display("FAIL step_pulse: unexpected pulse at cycle %0d, required none", cyc);
         end else begin
            exp_c = step_q.pop_front();
            if (cyc !== exp_c) begin
               errors++;
               $display("FAIL step_pulse: pulse at cycle %0d, required cycle %0d", cyc, exp_c);
            end
         end
      end
      if (pif.switch_chg === 1'b1) begin
         checks++;
         if (sw_cyc_q.size() == 0) begin
            errors++;
            $display("FAIL switch_chg: unexpected pulse at cycle %0d val %b", cyc, pif.switch_val);
         end else begin
            exp_c = sw_cyc_q.pop_front();
            exp_v = sw_val_q.pop_front();
            if (cyc !== exp_c || pif.switch_val !== exp_v) begin
               errors++;
               $display("FAIL switch_chg: cycle %0d val %b, required cycle %0d val %b",
                        cyc, pif.switch_val, exp_c, exp_v);
            end
         end
      end
   endtask

   task automatic test_reset();
      reset_n       = 1'b0;
      pif.s_button  = 1'b0;
      pif.w_button  = 1'b0;
      pif.switch_in = 4'b0000;
      for (int k = 1; k <= 3; k++) begin
         tick();
         checks++;
         if (pif.cpu_reset !== 1'b1 || pif.step_pulse !== 1'b0 ||
             pif.switch_val !== 4'b0000 || pif.switch_chg !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: cpu_reset=%b step=%b val=%b chg=%b, required 1 0 0000 0",
                     pif.cpu_reset, pif.step_pulse, pif.switch_val, pif.switch_chg);
         end
      end
      reset_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         checks++;
         if (pif.cpu_reset !== (k < 4)) begin
            errors++;
            $display("FAIL powerup_stretch: cycle+%0d cpu_reset=%b, required %b",
                     k, pif.cpu_reset, (k < 4));
         end
      end
   endtask

   task automatic test_reset_request();
      pif.w_button = 1'b1;
      for (int k = 1; k <= 26; k++) begin
         tick();
         if (k == 10) pif.w_button = 1'b0;
         checks++;
         if (pif.cpu_reset !== (k >= 6 && k < 20)) begin
            errors++;
            $display("FAIL reset_request: edge+%0d cpu_reset=%b, required %b",
                     k, pif.cpu_reset, (k >= 6 && k < 20));
         end
      end
   endtask

   task automatic test_step();
      int t0;
      pif.s_button = 1'b1;
      repeat (3) tick();
      pif.s_button = 1'b0;
      repeat (10) tick();

      pif.s_button = 1'b1;
      step_q.push_back(cyc + 6);
      repeat (10) tick();
      pif.s_button = 1'b0;
      repeat (12) tick();

      // Long hold: single pulse, or the repeat train when auto-repeat is built in.
      pif.s_button = 1'b1;
      t0 = cyc + 6;
      step_q.push_back(t0);
`ifdef PANEL_AUTO_REPEAT_EN
      step_q.push_back(t0 + 16);
      step_q.push_back(t0 + 24);
      step_q.push_back(t0 + 32);
      step_q.push_back(t0 + 40);
`endif
      repeat (44) tick();
      pif.s_button = 1'b0;
      repeat (14) tick();
      checks++;
      if (step_q.size() != 0) begin
         errors++;
         $display("FAIL step_missing: %0d pulses outstanding, required 0", step_q.size());
         step_q.delete();
      end
   endtask

   task automatic test_switches();
      pif.switch_in = 4'b1110;
      sw_cyc_q.push_back(cyc + 6);
      sw_val_q.push_back(4'b1110);
      repeat (10) tick();
      checks++;
      if (pif.switch_val !== 4'b1110) begin
         errors++;
         $display("FAIL switch_multi: val=%b, required 1110", pif.switch_val);
      end

      pif.switch_in = 4'b1111;
      repeat (2) tick();
      pif.switch_in = 4'b1110;
      repeat (10) tick();
      checks++;
      if (pif.switch_val !== 4'b1110) begin
         errors++;
         $display("FAIL switch_glitch: val=%b, required 1110", pif.switch_val);
      end

      pif.switch_in = 4'b0101;
      sw_cyc_q.push_back(cyc + 6);
      sw_val_q.push_back(4'b0101);
      repeat (10) tick();
      pif.switch_in = 4'b0000;
      sw_cyc_q.push_back(cyc + 6);
      sw_val_q.push_back(4'b0000);
      repeat (10) tick();
      checks++;
      if (sw_cyc_q.size() != 0 || pif.switch_val !== 4'b0000) begin
         errors++;
         $display("FAIL switch_seq: %0d events outstanding val=%b, required 0 0000",
                  sw_cyc_q.size(), pif.switch_val);
         sw_cyc_q.delete();
         sw_val_q.delete();
      end
   endtask

   task automatic test_conflict();
      pif.s_button = 1'b1;
      pif.w_button = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (k == 10) begin
            pif.s_button = 1'b0;
            pif.w_button = 1'b0;
         end
         if (k == 14) pif.w_button = 1'b1;
         if (k == 24) pif.w_button = 1'b0;
         checks++;
         if (pif.cpu_reset !== (k >= 6 && k < 34)) begin
            errors++;
            $display("FAIL conflict_reset: edge+%0d cpu_reset=%b, required %b",
                     k, pif.cpu_reset, (k >= 6 && k < 34));
         end
      end
   endtask

   task automatic test_reset_abort();
      pif.switch_in = 4'b1010;
      sw_cyc_q.push_back(cyc + 6);
      sw_val_q.push_back(4'b1010);
      repeat (8) tick();
      pif.w_button = 1'b1;
      repeat (8) tick();
      pif.w_button = 1'b0;
      repeat (7) tick();
      reset_n       = 1'b0;
      pif.switch_in = 4'b0000;
      #1;
      checks++;
      if (pif.cpu_reset !== 1'b1 || pif.switch_val !== 4'b0000 ||
          pif.switch_chg !== 1'b0 || pif.step_pulse !== 1'b0) begin
         errors++;
         $display("FAIL reset_abort: cpu_reset=%b val=%b chg=%b step=%b, required 1 0000 0 0",
                  pif.cpu_reset, pif.switch_val, pif.switch_chg, pif.step_pulse);
      end
      repeat (2) tick();
      reset_n = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         checks++;
         if (pif.cpu_reset !== (k < 4) || pif.switch_val !== 4'b0000) begin
            errors++;
            $display("FAIL abort_restretch: +%0d cpu_reset=%b val=%b, required %b 0000",
                     k, pif.cpu_reset, pif.switch_val, (k < 4));
         end
      end
   endtask

`ifdef PANEL_AUTO_REPEAT_EN
   task automatic test_repeat_reset();
      int t0;
      pif.s_button = 1'b1;
      t0 = cyc + 6;
      step_q.push_back(t0);
      step_q.push_back(t0 + 16);
      repeat (25) tick();
      reset_n      = 1'b0;
      pif.s_button = 1'b0;
      #1;
      checks++;
      if (pif.step_pulse !== 1'b0) begin
         errors++;
         $display("FAIL repeat_reset: step_pulse=%b, required 0", pif.step_pulse);
      end
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (20) tick();
      checks++;
      if (step_q.size() != 0) begin
         errors++;
         $display("FAIL repeat_missing: %0d pulses outstanding, required 0", step_q.size());
         step_q.delete();
      end
   endtask
`endif

   initial begin
      test_reset();
      test_reset_request();
      test_step();
      test_switches();
      test_conflict();
      test_reset_abort();
`ifdef PANEL_AUTO_REPEAT_EN
      test_repeat_reset();
`endif
      checks++;
      if (step_q.size() != 0 || sw_cyc_q.size() != 0) begin
         errors++;
         $display("FAIL final_queues: step=%0d switch=%0d outstanding, required 0 0",
                  step_q.size(), sw_cyc_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
